// File: rtl/rsv_station_if.sv
// Dispatch, broadcast and issue bus of the reservation station.
// master: dispatch source / broadcast driver / execution pipe side.
// slave : the reservation station itself.
interface rsv_station_if #(
    parameter int I_BL_MARC_REG = 6,
    parameter int D_BL_MARC_REG = 32,
    parameter int D_BL_MARC_IMM = 32,
    parameter int D_BL_MARC_OP  = 8
);
    // dispatch
    logic                     s_disp_valid;
    logic                     s_disp_ready;
    logic [I_BL_MARC_REG-1:0] i_preg_rd;
    logic [I_BL_MARC_REG-1:0] i_preg_r1;
    logic [I_BL_MARC_REG-1:0] i_preg_r2;
    logic                     s_preg_r1;
    logic                     s_preg_r2;
    logic [D_BL_MARC_REG-1:0] d_preg_r1;
    logic [D_BL_MARC_REG-1:0] d_preg_r2;
    logic [D_BL_MARC_IMM-1:0] d_imm;
    logic [D_BL_MARC_OP-1:0]  c_op;
    // result broadcast
    logic [I_BL_MARC_REG-1:0] i_preg_rb1;
    logic [D_BL_MARC_REG-1:0] d_preg_rb1;
    // issue
    logic                     s_iss_valid;
    logic                     s_iss_ready;
    logic [I_BL_MARC_REG-1:0] o_preg_rd;
    logic [D_BL_MARC_REG-1:0] o_d_r1;
    logic [D_BL_MARC_REG-1:0] o_d_r2;
    logic [D_BL_MARC_IMM-1:0] o_d_imm;
    logic [D_BL_MARC_OP-1:0]  o_c_op;

    modport master (
        output s_disp_valid, i_preg_rd, i_preg_r1, i_preg_r2, s_preg_r1, s_preg_r2,
               d_preg_r1, d_preg_r2, d_imm, c_op, i_preg_rb1, d_preg_rb1, s_iss_ready,
        input  s_disp_ready, s_iss_valid, o_preg_rd, o_d_r1, o_d_r2, o_d_imm, o_c_op
    );

    modport slave (
        input  s_disp_valid, i_preg_rd, i_preg_r1, i_preg_r2, s_preg_r1, s_preg_r2,
               d_preg_r1, d_preg_r2, d_imm, c_op, i_preg_rb1, d_preg_rb1, s_iss_ready,
        output s_disp_ready, s_iss_valid, o_preg_rd, o_d_r1, o_d_r2, o_d_imm, o_c_op
    );
endinterface

// File: rtl/rsv_station.sv
// Reservation station: compacting age-ordered queue (slot 0 oldest) that
// captures renamed micro-ops, wakes pending operands from the broadcast bus
// and issues the oldest fully-ready entry.
// Optional macro RSV_FWD_ISSUE_EN: a stored entry whose last pending operand
// is broadcast this cycle is selectable this cycle, with the broadcast data
// forwarded straight to the issue outputs.
module rsv_station #(
    parameter int ENTRIES       = 4,
    parameter int I_BL_MARC_REG = 6,
    parameter int D_BL_MARC_REG = 32,
    parameter int D_BL_MARC_IMM = 32,
    parameter int D_BL_MARC_OP  = 8
) (
    input  logic                           c_clock,
    input  logic                           c_reset,
    input  logic                           c_flush,
    input  logic                           c_pause,
    rsv_station_if.slave                   bus,
    output logic [$clog2(ENTRIES+1)-1:0]   s_count
);
    localparam int CW = $clog2(ENTRIES + 1);
    localparam int IW = $clog2(ENTRIES);

    typedef struct packed {
        logic                     v;
        logic                     rdy1;
        logic                     rdy2;
        logic [I_BL_MARC_REG-1:0] rd;
        logic [I_BL_MARC_REG-1:0] t1;
        logic [I_BL_MARC_REG-1:0] t2;
        logic [D_BL_MARC_REG-1:0] d1;
        logic [D_BL_MARC_REG-1:0] d2;
        logic [D_BL_MARC_IMM-1:0] imm;
        logic [D_BL_MARC_OP-1:0]  op;
    } entry_t;

    entry_t          slot [ENTRIES];   // registered entries
    entry_t          wk   [ENTRIES];   // entries after this cycle's wakeup
    entry_t          up   [ENTRIES];   // wk shifted down by one slot
    entry_t          nxt  [ENTRIES];   // next-state entries
    entry_t          new_e;
    logic [CW-1:0]   count;
    logic [CW-1:0]   wpos;
    logic [ENTRIES-1:0] ready;
    logic            found;
    logic [IW-1:0]   sel;
    logic            bcast;
    logic            do_disp;
    logic            do_issue;

    assign bcast   = (bus.i_preg_rb1 != '0);
    assign s_count = count;

    assign bus.s_disp_ready = (count < CW'(ENTRIES));
    assign bus.s_iss_valid  = found & ~c_pause & ~c_flush;

    assign do_issue = bus.s_iss_valid & bus.s_iss_ready;
    assign do_disp  = bus.s_disp_valid & bus.s_disp_ready & ~c_pause & ~c_flush;
    // a same-edge issue frees one slot below the tail
    assign wpos     = count - CW'(do_issue);

    // Operand wakeup from the broadcast bus for every valid stored entry
    always_comb begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            wk[i] = slot[i];
            if (slot[i].v && !slot[i].rdy1 && bcast && slot[i].t1 == bus.i_preg_rb1) begin
                wk[i].rdy1 = 1'b1;
                wk[i].d1   = bus.d_preg_rb1;
            end
            if (slot[i].v && !slot[i].rdy2 && bcast && slot[i].t2 == bus.i_preg_rb1) begin
                wk[i].rdy2 = 1'b1;
                wk[i].d2   = bus.d_preg_rb1;
            end
        end
    end

    // Per-entry readiness for selection
    always_comb begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
`ifdef RSV_FWD_ISSUE_EN
            ready[i] = wk[i].v & wk[i].rdy1 & wk[i].rdy2;
`else
            ready[i] = slot[i].v & slot[i].rdy1 & slot[i].rdy2;
`endif
        end
    end

    // Oldest-ready select: lowest index wins
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!found && ready[i]) begin
                found = 1'b1;
                sel   = IW'(i);
            end
        end
    end

    // Issue field mux, zero when nothing is selectable
    always_comb begin
        bus.o_preg_rd = '0;
        bus.o_d_r1    = '0;
        bus.o_d_r2    = '0;
        bus.o_d_imm   = '0;
        bus.o_c_op    = '0;
        if (found) begin
`ifdef RSV_FWD_ISSUE_EN
            bus.o_preg_rd = wk[sel].rd;
            bus.o_d_r1    = wk[sel].d1;
            bus.o_d_r2    = wk[sel].d2;
            bus.o_d_imm   = wk[sel].imm;
            bus.o_c_op    = wk[sel].op;
`else
            bus.o_preg_rd = slot[sel].rd;
            bus.o_d_r1    = slot[sel].d1;
            bus.o_d_r2    = slot[sel].d2;
            bus.o_d_imm   = slot[sel].imm;
            bus.o_c_op    = slot[sel].op;
`endif
        end
    end

    // Incoming entry, including same-cycle snoop of the broadcast
    always_comb begin
        new_e      = '0;
        new_e.v    = 1'b1;
        new_e.rd   = bus.i_preg_rd;
        new_e.t1   = bus.i_preg_r1;
        new_e.t2   = bus.i_preg_r2;
        new_e.d1   = bus.d_preg_r1;
        new_e.d2   = bus.d_preg_r2;
        new_e.imm  = bus.d_imm;
        new_e.op   = bus.c_op;
        new_e.rdy1 = bus.s_preg_r1 | (bus.i_preg_r1 == '0);
        new_e.rdy2 = bus.s_preg_r2 | (bus.i_preg_r2 == '0);
        if (!new_e.rdy1 && bcast && bus.i_preg_r1 == bus.i_preg_rb1) begin
            new_e.rdy1 = 1'b1;
            new_e.d1   = bus.d_preg_rb1;
        end
        if (!new_e.rdy2 && bcast && bus.i_preg_r2 == bus.i_preg_rb1) begin
            new_e.rdy2 = 1'b1;
            new_e.d2   = bus.d_preg_rb1;
        end
    end

    // Next queue contents: compaction uses the woken copies so that wakeups
    // of shifted entries are not lost, then the dispatch lands at the tail
    always_comb begin
        for (int unsigned i = 0; i < ENTRIES - 1; i++) begin
            up[i] = wk[i + 1];
        end
        up[ENTRIES-1] = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            nxt[i] = (do_issue && IW'(i) >= sel) ? up[i] : wk[i];
            if (do_disp && CW'(i) == wpos) begin
                nxt[i] = new_e;
            end
        end
    end

    // Queue state and occupancy; flush clears everything and drops dispatch
    always_ff @(posedge c_clock or negedge c_reset) begin
        if (!c_reset) begin
            count <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                slot[i] <= '0;
            end
        end else if (c_flush) begin
            count <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                slot[i] <= '0;
            end
        end else begin
            count <= count + CW'(do_disp) - CW'(do_issue);
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                slot[i] <= nxt[i];
            end
        end
    end
endmodule

// File: tb/tb_rsv_station.sv
// Directed bench for rsv_station (default 4 entries).
module tb_rsv_station;
    localparam int ENTRIES = 4;
    localparam int RW      = 6;
    localparam int DW      = 32;
    localparam int IMW     = 32;
    localparam int OPW     = 8;

    logic       c_clock = 1'b0;
    logic       c_reset;
    logic       c_flush;
    logic       c_pause;
    logic [2:0] s_count;

    int n_tests = 0;
    int n_fail  = 0;

    rsv_station_if #(
        .I_BL_MARC_REG(RW),
        .D_BL_MARC_REG(DW),
        .D_BL_MARC_IMM(IMW),
        .D_BL_MARC_OP (OPW)
    ) bus ();

    rsv_station #(
        .ENTRIES      (ENTRIES),
        .I_BL_MARC_REG(RW),
        .D_BL_MARC_REG(DW),
        .D_BL_MARC_IMM(IMW),
        .D_BL_MARC_OP (OPW)
    ) dut (
        .c_clock(c_clock),
        .c_reset(c_reset),
        .c_flush(c_flush),
        .c_pause(c_pause),
        .bus    (bus),
        .s_count(s_count)
    );

    always #5 c_clock = ~c_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge c_clock);
        #1;
    endtask

    task automatic idle();
        c_flush          = 1'b0;
        c_pause          = 1'b0;
        bus.s_disp_valid = 1'b0;
        bus.i_preg_rd    = '0;
        bus.i_preg_r1    = '0;
        bus.i_preg_r2    = '0;
        bus.s_preg_r1    = 1'b0;
        bus.s_preg_r2    = 1'b0;
        bus.d_preg_r1    = '0;
        bus.d_preg_r2    = '0;
        bus.d_imm        = '0;
        bus.c_op         = '0;
        bus.i_preg_rb1   = '0;
        bus.d_preg_rb1   = '0;
    endtask

    task automatic disp(input logic [5:0] rd, input logic [5:0] r1, input logic s1,
                        input logic [31:0] d1, input logic [5:0] r2, input logic s2,
                        input logic [31:0] d2);
        bus.s_disp_valid = 1'b1;
        bus.i_preg_rd    = rd;
        bus.i_preg_r1    = r1;
        bus.s_preg_r1    = s1;
        bus.d_preg_r1    = d1;
        bus.i_preg_r2    = r2;
        bus.s_preg_r2    = s2;
        bus.d_preg_r2    = d2;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        c_reset = 1'b0;
        idle();
        bus.s_iss_ready = 1'b0;
        #2;
        check("rst_count",      32'(s_count), 0);
        check("rst_iss_valid",  32'(bus.s_iss_valid), 0);
        check("rst_disp_ready", 32'(bus.s_disp_ready), 1);
        check("rst_o_d_r1",     bus.o_d_r1, 0);
        tick();
        c_reset = 1'b1;

        // ready dispatch issues next cycle
        bus.s_iss_ready = 1'b1;
        disp(6'd3, 6'd5, 1'b1, 32'h11, 6'd6, 1'b1, 32'h22);
        bus.d_imm = 32'h77;
        bus.c_op  = 8'h42;
        tick();
        idle();
        #1;
        check("rd_count1",  32'(s_count), 1);
        check("rd_valid",   32'(bus.s_iss_valid), 1);
        check("rd_d_r1",    bus.o_d_r1, 32'h11);
        check("rd_d_r2",    bus.o_d_r2, 32'h22);
        check("rd_preg_rd", 32'(bus.o_preg_rd), 3);
        check("rd_imm",     bus.o_d_imm, 32'h77);
        check("rd_op",      32'(bus.o_c_op), 32'h42);
        tick();
        check("rd_count0",  32'(s_count), 0);
        check("rd_valid0",  32'(bus.s_iss_valid), 0);

        // wakeup from broadcast two cycles after dispatch
        disp(6'd4, 6'd7, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0);
        tick();
        idle();
        #1;
        check("wk_pending",   32'(bus.s_iss_valid), 0);
        check("wk_count",     32'(s_count), 1);
        tick();
        bus.i_preg_rb1 = 6'd7;
        bus.d_preg_rb1 = 32'hABCD;
        #1;
`ifdef RSV_FWD_ISSUE_EN
        check("wk_fwd_valid", 32'(bus.s_iss_valid), 1);
        check("wk_fwd_d_r1",  bus.o_d_r1, 32'hABCD);
        tick();
        idle();
        #1;
`else
        check("wk_bc_valid",  32'(bus.s_iss_valid), 0);
        tick();
        idle();
        #1;
        check("wk_valid",     32'(bus.s_iss_valid), 1);
        check("wk_d_r1",      bus.o_d_r1, 32'hABCD);
        tick();
`endif
        check("wk_count0",    32'(s_count), 0);

        // same-cycle dispatch snoop
        disp(6'd8, 6'd0, 1'b0, 32'h0, 6'd9, 1'b0, 32'h0);
        bus.i_preg_rb1 = 6'd9;
        bus.d_preg_rb1 = 32'h5;
        tick();
        idle();
        #1;
        check("sn_valid", 32'(bus.s_iss_valid), 1);
        check("sn_d_r2",  bus.o_d_r2, 32'h5);
        tick();
        check("sn_count0", 32'(s_count), 0);

        // fill, age order, full back-pressure
        bus.s_iss_ready = 1'b0;
        disp(6'd1, 6'd12, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            disp(6'(k + 2), 6'd0, 1'b1, 32'h101 + 32'(k), 6'd0, 1'b0, 32'h0);
            tick();
        end
        idle();
        #1;
        check("fu_count4",  32'(s_count), 4);
        check("fu_dready",  32'(bus.s_disp_ready), 0);
        check("fu_sel1",    32'(bus.o_preg_rd), 2);
        check("fu_sel1_d",  bus.o_d_r1, 32'h101);
        disp(6'd9, 6'd0, 1'b1, 32'h99, 6'd0, 1'b1, 32'h99);
        tick();
        idle();
        #1;
        check("fu_nodisp",  32'(s_count), 4);
        check("fu_hold",    32'(bus.o_preg_rd), 2);
        bus.s_iss_ready = 1'b1;
        #1;
        tick();
        check("fu_sel2",    32'(bus.o_preg_rd), 3);
        check("fu_count3",  32'(s_count), 3);
        tick();
        check("fu_sel3",    32'(bus.o_preg_rd), 4);
        tick();
        check("fu_count1",  32'(s_count), 1);
        check("fu_old_pend", 32'(bus.s_iss_valid), 0);
        bus.s_iss_ready = 1'b0;
        disp(6'd10, 6'd0, 1'b1, 32'h55, 6'd0, 1'b1, 32'h0);
        bus.i_preg_rb1 = 6'd12;
        bus.d_preg_rb1 = 32'hBEEF;
        tick();
        idle();
        #1;
        check("fu_count2",  32'(s_count), 2);
        check("fu_old_sel", 32'(bus.o_preg_rd), 1);
        check("fu_old_d",   bus.o_d_r1, 32'hBEEF);
        bus.s_iss_ready = 1'b1;
        tick();
        check("fu_new_sel", 32'(bus.o_preg_rd), 10);
        check("fu_new_d",   bus.o_d_r1, 32'h55);
        tick();
        check("fu_empty",   32'(s_count), 0);

        // pause with wakeup, then flush dropping a dispatch
        disp(6'd1, 6'd20, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0);
        tick();
        disp(6'd2, 6'd0, 1'b0, 32'h2, 6'd21, 1'b0, 32'h0);
        tick();
        disp(6'd3, 6'd22, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0);
        tick();
        idle();
        c_pause        = 1'b1;
        bus.i_preg_rb1 = 6'd20;
        bus.d_preg_rb1 = 32'h1234;
        #1;
        check("pf_count3",   32'(s_count), 3);
        check("pf_paused",   32'(bus.s_iss_valid), 0);
        tick();
        bus.i_preg_rb1 = '0;
        bus.d_preg_rb1 = '0;
        #1;
        check("pf_paused2",  32'(bus.s_iss_valid), 0);
        check("pf_count3b",  32'(s_count), 3);
        c_pause = 1'b0;
        #1;
        check("pf_woke",     32'(bus.s_iss_valid), 1);
        check("pf_woke_d",   bus.o_d_r1, 32'h1234);
        c_flush = 1'b1;
        disp(6'd5, 6'd0, 1'b1, 32'h7, 6'd0, 1'b1, 32'h7);
        #1;
        check("pf_flush_v",  32'(bus.s_iss_valid), 0);
        tick();
        idle();
        #1;
        check("pf_count0",   32'(s_count), 0);
        check("pf_dropped",  32'(bus.s_iss_valid), 0);
        check("pf_dready",   32'(bus.s_disp_ready), 1);

        // asynchronous reset while an issue is offered
        bus.s_iss_ready = 1'b0;
        disp(6'd7, 6'd0, 1'b1, 32'h66, 6'd0, 1'b1, 32'h0);
        tick();
        idle();
        #1;
        check("ar_valid1",  32'(bus.s_iss_valid), 1);
        check("ar_count1",  32'(s_count), 1);
        c_reset = 1'b0;
        #1;
        check("ar_valid0",  32'(bus.s_iss_valid), 0);
        check("ar_count0",  32'(s_count), 0);
        check("ar_o_rd",    32'(bus.o_preg_rd), 0);
        #1;
        c_reset = 1'b1;
        tick();
        check("ar_after",   32'(s_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
